axi4lite_regbank_slave: RTL
===========================

// Module: axi4lite_regbank_slave
// PURPOSE
// Parametrised AXI4-Lite slave register bank: NUM_REGS words of DATA_W bits, byte-strobe writes,
//   optional read-only status slots, SLVERR decode. Sits behind the interconnect on the slave side.
// Exposes the bank to core logic in parallel and emits per-register write pulses.
// Independent read/write FSMs; AW and W are accepted in any order.
// PARAMETERS
// ADDR_W    32    AW_ADDR/AR_ADDR width
// DATA_W    32    data width, 32 or 64; STRB_W = DATA_W/8 (localparam)
// NUM_REGS  16    register count, >=1
// BASE_ADDR 0     byte address of register 0, STRB_W-aligned
// RO_MASK   0     NUM_REGS-bit mask; bit i=1: reg i read-only, reads sts_i word i
// PORTS
// A_CLK     in   1                clock, all logic on rising edge
// A_RST     in   1                synchronous reset, active-high
// AW_VALID/AW_READY in/out 1; AW_ADDR in ADDR_W; AW_PROT in 3
// W_VALID/W_READY   in/out 1; W_DATA in DATA_W; W_STRB in STRB_W
// B_VALID out 1; B_READY in 1; B_RESP out 2
// AR_VALID/AR_READY in/out 1; AR_ADDR in ADDR_W; AR_PROT in 3
// R_VALID out 1; R_READY in 1; R_DATA out DATA_W; R_RESP out 2
// regs_o    out  NUM_REGS*DATA_W  register contents, word i at [i*DATA_W +: DATA_W]
// sts_i     in   NUM_REGS*DATA_W  status words for RO slots (unused bits ignored)
// wr_pulse_o out NUM_REGS         1-cycle strobe per successful write to reg i
// BEHAVIOUR
// Reset: all READY/VALID, B_RESP, R_RESP, R_DATA, wr_pulse_o = 0; all RW regs = 0; FSMs to IDLE.
//   Reset mid-transaction drops it: no B/R response issued, partial captures discarded.
// Decode: idx = (ADDR-BASE_ADDR)>>log2(STRB_W); addr low log2(STRB_W) bits ignored.
//   Miss if ADDR<BASE_ADDR or idx>=NUM_REGS -> SLVERR (2'b10). Write to RO slot -> SLVERR.
// Write FSM: WIDLE -> WEXEC -> WRESP -> WIDLE.
//   WIDLE: AW_READY=!aw_held, W_READY=!w_held; each handshake latches addr/prot or data/strb.
//   Both held (same or different edges) at edge N -> WEXEC for one cycle.
//   Edge N+1: write performed (byte j updated iff W_STRB[j]), B_VALID=1, B_RESP set,
//     wr_pulse_o[idx]=1 for exactly the cycle after N+1 (OKAY only). W_STRB=0 still OKAY + pulse.
//   WRESP: B_VALID/B_RESP held stable until B_READY; on handshake -> WIDLE, READYs reassert next cycle.
//   Error write: no register change, no pulse.
// Read FSM: RIDLE -> RRESP -> RIDLE.
//   RIDLE: AR_READY=1. AR handshake at edge N: R_VALID=1 from N, R_DATA sampled at edge N
//     (RO slot -> sts_i word, else reg), R_RESP set; error -> R_DATA=0.
//   RRESP: AR_READY=0; R_DATA/R_RESP/R_VALID stable until R_READY; handshake -> RIDLE.
// Simultaneous read/write same reg: read at the write edge returns pre-write value.
// One outstanding transaction per direction; read and write proceed concurrently.
// Never combinational VALID->READY paths; all outputs registered.
// CONFIGURATION
// AXI4LITE_PROT_CHECK_EN defined: access with PROT[0]=0 (unprivileged) -> SLVERR;
//   write suppressed, no pulse; read R_DATA=0. Checked in addition to decode errors.
// Undefined: AW_PROT/AR_PROT ignored, no logic generated for them.
// TESTING
// Reset -> all outputs 0, reads of RW regs return 0x0000_0000 OKAY.
// AW@0x04 then W(0xDEADBEEF,STRB=4'hF) 3 cycles later -> reg1=0xDEADBEEF, B_RESP=00, one pulse bit1.
// Write reg2=0x11223344, then W 0xAABBCCDD STRB=4'b0101 -> read reg2 = 0x11BB33DD.
// Write to 0x40 (NUM_REGS=16) -> B_RESP=10, no pulse; read 0x40 -> R_RESP=10, R_DATA=0.
// RO_MASK bit3, sts_i word3=0xCAFE0003: read 0x0C -> 0xCAFE0003 OKAY; write 0x0C -> SLVERR.
// B_READY/R_READY held low 5 cycles -> responses stable, no new AW/AR accepted; A_RST mid-WRESP drops B.

Source files
------------

// File: rtl/axi4lite_regbank_slave.sv
// -----------------------------------------------------------------------------
// axi4lite_regbank_slave
// AXI4-Lite slave register bank of NUM_REGS words of DATA_W bits. Writes honour
// byte strobes, slots flagged in RO_MASK are read-only and read back the
// matching sts_i word, and out-of-range or read-only accesses answer SLVERR.
// The bank is exposed in parallel on regs_o, and every successful write pulses
// the matching wr_pulse_o bit for one cycle. Read and write channels run as
// independent FSMs, and AW/W may arrive in either order.
//
// Optional feature macro: AXI4LITE_PROT_CHECK_EN
//   When defined, accesses with PROT[0]=0 (unprivileged) answer SLVERR: writes
//   are suppressed and reads return zero. When undefined, AW_PROT/AR_PROT are
//   ignored.
//
// Ports
//   A_CLK, A_RST          clock (rising edge), synchronous active-high reset
//   AW_*, W_*, B_*        AXI4-Lite write address / data / response channels
//   AR_*, R_*             AXI4-Lite read address / data channels
//   regs_o                register contents, word i at [i*DATA_W +: DATA_W]
//   sts_i                 status words returned for read-only slots
//   wr_pulse_o            one-cycle strobe per successful write to reg i
// -----------------------------------------------------------------------------
module axi4lite_regbank_slave #(
  parameter int                  ADDR_W    = 32,
  parameter int                  DATA_W    = 32,
  parameter int                  NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic                         A_CLK,
  input  logic                         A_RST,
  input  logic                         AW_VALID,
  output logic                         AW_READY,
  input  logic [ADDR_W-1:0]            AW_ADDR,
  input  logic [2:0]                   AW_PROT,
  input  logic                         W_VALID,
  output logic                         W_READY,
  input  logic [DATA_W-1:0]            W_DATA,
  input  logic [DATA_W/8-1:0]          W_STRB,
  output logic                         B_VALID,
  input  logic                         B_READY,
  output logic [1:0]                   B_RESP,
  input  logic                         AR_VALID,
  output logic                         AR_READY,
  input  logic [ADDR_W-1:0]            AR_ADDR,
  input  logic [2:0]                   AR_PROT,
  output logic                         R_VALID,
  input  logic                         R_READY,
  output logic [DATA_W-1:0]            R_DATA,
  output logic [1:0]                   R_RESP,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  input  logic [NUM_REGS*DATA_W-1:0]   sts_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIDLE, WEXEC, WRESP} wstate_t;
  typedef enum logic       {RIDLE, RRESP}        rstate_t;

  wstate_t             wstate_r, wstate_nxt_s;
  rstate_t             rstate_r, rstate_nxt_s;
  logic                aw_held_r, aw_held_nxt_s, w_held_r, w_held_nxt_s;
  logic                aw_ready_r, w_ready_r, ar_ready_r;
  logic [ADDR_W-1:0]   aw_addr_r;
  logic [DATA_W-1:0]   w_data_r;
  logic [STRB_W-1:0]   w_strb_r;
  logic                b_valid_r, r_valid_r;
  logic [1:0]          b_resp_r, r_resp_r;
  logic [DATA_W-1:0]   r_data_r;
  logic [NUM_REGS-1:0] wr_pulse_r;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [ADDR_W-1:0]   aw_off_s, ar_off_s;
  logic [IDX_W-1:0]    aw_idx_s, ar_idx_s;
  logic                aw_miss_s, ar_miss_s, aw_err_s, ar_err_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic                aw_hs_s, w_hs_s, ar_hs_s;
  logic                unused_prot_s;

`ifdef AXI4LITE_PROT_CHECK_EN
  logic aw_priv_r;
  assign unused_prot_s = &{1'b0, AW_PROT[2:1], AR_PROT[2:1]};
`else
  assign unused_prot_s = &{1'b0, AW_PROT, AR_PROT};
`endif

  assign aw_hs_s = AW_VALID && aw_ready_r;
  assign w_hs_s  = W_VALID && w_ready_r;
  assign ar_hs_s = AR_VALID && ar_ready_r;

  // Write address decode on the latched AW address.
  always_comb begin
    aw_off_s = (aw_addr_r - BASE_ADDR) >> SHIFT;
    aw_idx_s = aw_off_s[IDX_W-1:0];
    if (aw_addr_r < BASE_ADDR) aw_miss_s = 1'b1;
    else if (aw_off_s >= ADDR_W'(NUM_REGS)) aw_miss_s = 1'b1;
    else aw_miss_s = 1'b0;
    // RO_MASK is only indexed once the index is known to be in range.
    if (aw_miss_s) aw_err_s = 1'b1;
    else if (RO_MASK[aw_idx_s]) aw_err_s = 1'b1;
`ifdef AXI4LITE_PROT_CHECK_EN
    else if (!aw_priv_r) aw_err_s = 1'b1;
`endif
    else aw_err_s = 1'b0;
  end

  // Read address decode and read-data mux on the live AR address.
  always_comb begin
    ar_off_s = (AR_ADDR - BASE_ADDR) >> SHIFT;
    ar_idx_s = ar_off_s[IDX_W-1:0];
    if (AR_ADDR < BASE_ADDR) ar_miss_s = 1'b1;
    else if (ar_off_s >= ADDR_W'(NUM_REGS)) ar_miss_s = 1'b1;
    else ar_miss_s = 1'b0;
    if (ar_miss_s) ar_err_s = 1'b1;
`ifdef AXI4LITE_PROT_CHECK_EN
    else if (!AR_PROT[0]) ar_err_s = 1'b1;
`endif
    else ar_err_s = 1'b0;
    if (ar_err_s) rd_word_s = '0;
    else if (RO_MASK[ar_idx_s]) rd_word_s = sts_i[ar_idx_s*DATA_W +: DATA_W];
    else rd_word_s = regs_r[ar_idx_s];
  end

  // Write FSM next state and AW/W hold flags.
  always_comb begin
    wstate_nxt_s  = wstate_r;
    aw_held_nxt_s = aw_held_r;
    w_held_nxt_s  = w_held_r;
    case (wstate_r)
      WIDLE: begin
        if (aw_hs_s) aw_held_nxt_s = 1'b1;
        else aw_held_nxt_s = aw_held_r;
        if (w_hs_s) w_held_nxt_s = 1'b1;
        else w_held_nxt_s = w_held_r;
        if (aw_held_nxt_s && w_held_nxt_s) wstate_nxt_s = WEXEC;
        else wstate_nxt_s = WIDLE;
      end
      WEXEC: wstate_nxt_s = WRESP;
      WRESP: begin
        if (b_valid_r && B_READY) begin
          wstate_nxt_s  = WIDLE;
          aw_held_nxt_s = 1'b0;
          w_held_nxt_s  = 1'b0;
        end else begin
          wstate_nxt_s = WRESP;
        end
      end
      default: begin
        wstate_nxt_s  = WIDLE;
        aw_held_nxt_s = 1'b0;
        w_held_nxt_s  = 1'b0;
      end
    endcase
  end

  // Read FSM next state.
  always_comb begin
    rstate_nxt_s = rstate_r;
    case (rstate_r)
      RIDLE: begin
        if (ar_hs_s) rstate_nxt_s = RRESP;
        else rstate_nxt_s = RIDLE;
      end
      RRESP: begin
        if (r_valid_r && R_READY) rstate_nxt_s = RIDLE;
        else rstate_nxt_s = RRESP;
      end
      default: rstate_nxt_s = RIDLE;
    endcase
  end

  // State registers, hold flags and registered READYs.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      wstate_r   <= WIDLE;
      rstate_r   <= RIDLE;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      ar_ready_r <= 1'b0;
    end else begin
      wstate_r   <= wstate_nxt_s;
      rstate_r   <= rstate_nxt_s;
      aw_held_r  <= aw_held_nxt_s;
      w_held_r   <= w_held_nxt_s;
      aw_ready_r <= (wstate_nxt_s == WIDLE) && !aw_held_nxt_s;
      w_ready_r  <= (wstate_nxt_s == WIDLE) && !w_held_nxt_s;
      ar_ready_r <= (rstate_nxt_s == RIDLE);
    end
  end

  // Capture of AW and W payloads on their handshakes.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      aw_addr_r <= '0;
      w_data_r  <= '0;
      w_strb_r  <= '0;
`ifdef AXI4LITE_PROT_CHECK_EN
      aw_priv_r <= 1'b0;
`endif
    end else begin
      if (aw_hs_s) begin
        aw_addr_r <= AW_ADDR;
`ifdef AXI4LITE_PROT_CHECK_EN
        aw_priv_r <= AW_PROT[0];
`endif
      end
      if (w_hs_s) begin
        w_data_r <= W_DATA;
        w_strb_r <= W_STRB;
      end
    end
  end

  // Register update, B response and write pulse, all launched from WEXEC.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      b_valid_r  <= 1'b0;
      b_resp_r   <= RESP_OKAY;
      wr_pulse_r <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
    end else begin
      wr_pulse_r <= '0;
      if (wstate_r == WEXEC) begin
        b_valid_r <= 1'b1;
        b_resp_r  <= aw_err_s ? RESP_SLVERR : RESP_OKAY;
        if (!aw_err_s) begin
          wr_pulse_r[aw_idx_s] <= 1'b1;
          for (int j = 0; j < STRB_W; j++) begin
            if (w_strb_r[j]) regs_r[aw_idx_s][j*8 +: 8] <= w_data_r[j*8 +: 8];
          end
        end
      end else if (b_valid_r && B_READY) begin
        b_valid_r <= 1'b0;
      end
    end
  end

  // R channel: data sampled at the AR handshake edge, held until R_READY.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      r_valid_r <= 1'b0;
      r_resp_r  <= RESP_OKAY;
      r_data_r  <= '0;
    end else if (rstate_r == RIDLE && ar_hs_s) begin
      r_valid_r <= 1'b1;
      r_resp_r  <= ar_err_s ? RESP_SLVERR : RESP_OKAY;
      r_data_r  <= rd_word_s;
    end else if (r_valid_r && R_READY) begin
      r_valid_r <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = regs_r[g];
  end

  assign AW_READY   = aw_ready_r;
  assign W_READY    = w_ready_r;
  assign AR_READY   = ar_ready_r;
  assign B_VALID    = b_valid_r;
  assign B_RESP     = b_resp_r;
  assign R_VALID    = r_valid_r;
  assign R_RESP     = r_resp_r;
  assign R_DATA     = r_data_r;
  assign wr_pulse_o = wr_pulse_r;

endmodule
